// File: rtl/gpio_input_debounce.sv
// gpio_input_debounce
//   Conditions raw board inputs (slide switches, push keys) before the GPIO register block
//   samples them. Every pin is synchronised into clk and then debounced by its own stability
//   counter. Keys are active-low at the pins and are presented active-high ("pressed").
//
// Ports
//   clk              in   1     system clock
//   reset_n          in   1     asynchronous, active-low reset
//   i_sw_raw         in   NSW   raw switch pins, asynchronous, 1 = on
//   i_key_raw        in   NKEY  raw key pins, asynchronous, 0 = pressed
//   o_sw             out  NSW   debounced switch state, 1 = on
//   o_key            out  NKEY  debounced key state, 1 = pressed
//   o_key_press      out  NKEY  sticky press flags            (GPIO_KEY_EVENT_EN only)
//   i_key_press_clr  in   NKEY  per-bit clear for o_key_press (GPIO_KEY_EVENT_EN only)
//
// Build option
//   GPIO_KEY_EVENT_EN  when defined, adds sticky key-press flags with per-bit clear.
//                      When undefined, the event ports and logic do not exist.

module gpio_input_debounce #(
    parameter int unsigned NSW             = 10,
    parameter int unsigned NKEY            = 4,
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic [NSW-1:0]  i_sw_raw,
    input  logic [NKEY-1:0] i_key_raw,
    output logic [NSW-1:0]  o_sw,
    output logic [NKEY-1:0] o_key
`ifdef GPIO_KEY_EVENT_EN
    ,
    output logic [NKEY-1:0] o_key_press,
    input  logic [NKEY-1:0] i_key_press_clr
`endif
);

    localparam int unsigned NCH   = NSW + NKEY;
    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);

    // Key channels sit in the upper bits. Their synchroniser resets to 1 (released) and they are
    // inverted after the chain, so every channel leaves reset at s == q == 0: no false event.
    localparam logic [NCH-1:0] KEY_MASK = {{NKEY{1'b1}}, {NSW{1'b0}}};

    typedef enum logic {
        StStable,
        StCounting
    } state_e;

    logic [NCH-1:0]   r_sync [SYNC_STAGES];
    logic [NCH-1:0]   w_s;
    logic [NCH-1:0]   r_q;
    logic [NCH-1:0]   w_q_d;
    state_e           r_state [NCH];
    state_e           w_state_d [NCH];
    logic [CNT_W-1:0] r_cnt [NCH];
    logic [CNT_W-1:0] w_cnt_d [NCH];

    // Synchroniser chains, one per channel.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                r_sync[i] <= KEY_MASK;
            end
        end else begin
            r_sync[0] <= {i_key_raw, i_sw_raw};
            for (int i = 1; i < SYNC_STAGES; i++) begin
                r_sync[i] <= r_sync[i-1];
            end
        end
    end

    assign w_s = r_sync[SYNC_STAGES-1] ^ KEY_MASK;

    // Per-channel debounce state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_q <= '0;
            for (int i = 0; i < NCH; i++) begin
                r_state[i] <= StStable;
                r_cnt[i]   <= '0;
            end
        end else begin
            r_q <= w_q_d;
            for (int i = 0; i < NCH; i++) begin
                r_state[i] <= w_state_d[i];
                r_cnt[i]   <= w_cnt_d[i];
            end
        end
    end

    // Per-channel next state. The counter includes the first differing sample, so the output
    // moves once s has differed from q for DEBOUNCE_CYCLES+1 consecutive cycles.
    always_comb begin
        w_q_d = r_q;
        for (int i = 0; i < NCH; i++) begin
            w_state_d[i] = r_state[i];
            w_cnt_d[i]   = r_cnt[i];
            case (r_state[i])
                StStable: begin
                    if (w_s[i] != r_q[i]) begin
                        w_state_d[i] = StCounting;
                        w_cnt_d[i]   = CNT_W'(1);
                    end else begin
                        w_cnt_d[i] = '0;
                    end
                end
                StCounting: begin
                    if (w_s[i] == r_q[i]) begin
                        // Glitch: input returned before the window elapsed.
                        w_state_d[i] = StStable;
                        w_cnt_d[i]   = '0;
                    end else if (r_cnt[i] == CNT_MAX) begin
                        w_q_d[i]     = w_s[i];
                        w_state_d[i] = StStable;
                        w_cnt_d[i]   = '0;
                    end else begin
                        w_cnt_d[i] = r_cnt[i] + CNT_W'(1);
                    end
                end
                default: begin
                    w_state_d[i] = StStable;
                    w_cnt_d[i]   = '0;
                end
            endcase
        end
    end

    assign o_sw  = r_q[NSW-1:0];
    assign o_key = r_q[NCH-1:NSW];

`ifdef GPIO_KEY_EVENT_EN
    logic [NKEY-1:0] r_key_prev;
    logic [NKEY-1:0] r_key_press;
    logic [NKEY-1:0] w_key_rise;

    assign w_key_rise = o_key & ~r_key_prev;

    // A rise and a clear on the same cycle keep the flag set so no press is lost.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_key_prev  <= '0;
            r_key_press <= '0;
        end else begin
            r_key_prev  <= o_key;
            r_key_press <= (r_key_press & ~i_key_press_clr) | w_key_rise;
        end
    end

    assign o_key_press = r_key_press;
`endif

endmodule

// File: tb/tb_gpio_input_debounce.sv
module tb_gpio_input_debounce;

    localparam int unsigned NSW  = 10;
    localparam int unsigned NKEY = 4;
    localparam int unsigned SYNC = 2;
    localparam int unsigned DEB  = 8;
    localparam int unsigned N    = NSW + NKEY;
`ifdef GPIO_KEY_EVENT_EN
    localparam int unsigned OW = N + NKEY;
`else
    localparam int unsigned OW = N;
`endif

    logic            clk = 1'b0;
    logic            reset_n;
    logic [NSW-1:0]  sw_raw;
    logic [NKEY-1:0] key_raw;
    logic [NSW-1:0]  sw;
    logic [NKEY-1:0] key;
`ifdef GPIO_KEY_EVENT_EN
    logic [NKEY-1:0] kp;
    logic [NKEY-1:0] kp_clr;
`endif

    gpio_input_debounce #(
        .NSW             (NSW),
        .NKEY            (NKEY),
        .SYNC_STAGES     (SYNC),
        .DEBOUNCE_CYCLES (DEB)
    ) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .i_sw_raw        (sw_raw),
        .i_key_raw       (key_raw),
        .o_sw            (sw),
        .o_key           (key)
`ifdef GPIO_KEY_EVENT_EN
        ,
        .o_key_press     (kp),
        .i_key_press_clr (kp_clr)
`endif
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;
    logic [OW-1:0] exp_q [$];

    function automatic logic [OW-1:0] dut_out();
`ifdef GPIO_KEY_EVENT_EN
        return {kp, key, sw};
`else
        return {key, sw};
`endif
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: a channel's output takes the synchronised level once the last DEB+1
    // synchronised samples all disagree with the current output. Synchronised sample seen at
    // edge t is the pin value captured SYNC edges earlier.
    initial begin : model
        logic [N-1:0]    dl [SYNC];
        logic [N-1:0]    win [$];
        logic [N-1:0]    q;
        logic [N-1:0]    vis;
        logic [N-1:0]    all1;
        logic [N-1:0]    any1;
        logic [NKEY-1:0] mkp;
        logic [NKEY-1:0] k1;
        logic [NKEY-1:0] k2;
        for (int i = 0; i < SYNC; i++) dl[i] = '0;
        q = '0; mkp = '0; k1 = '0; k2 = '0;
        forever begin
            @(posedge clk);
            if (!reset_n) begin
                for (int i = 0; i < SYNC; i++) dl[i] = '0;
                win.delete();
                q = '0; mkp = '0; k1 = '0; k2 = '0;
            end else begin
                vis = dl[SYNC-1];
                for (int i = SYNC - 1; i > 0; i--) dl[i] = dl[i-1];
                dl[0] = {~key_raw, sw_raw};
                win.push_back(vis);
                if (win.size() > DEB + 1) void'(win.pop_front());
                if (win.size() == DEB + 1) begin
                    all1 = '1;
                    any1 = '0;
                    foreach (win[j]) begin
                        all1 &= win[j];
                        any1 |= win[j];
                    end
                    q = all1 | (q & any1);
                end
`ifdef GPIO_KEY_EVENT_EN
                mkp = (mkp & ~kp_clr) | (k1 & ~k2);
                k2  = k1;
                k1  = q[N-1:NSW];
`endif
            end
`ifdef GPIO_KEY_EVENT_EN
            exp_q.push_back({mkp, q});
`else
            exp_q.push_back(q);
`endif
        end
    end

    // Monitor: one expected word per cycle, compared mid-cycle.
    initial begin : monitor
        logic [OW-1:0] e;
        forever begin
            @(negedge clk);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                if (!reset_n) e = '0;
                chk("scoreboard", 32'(dut_out()), 32'(e));
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Counts edges until output bit (index into {key, sw}) reaches val; -1 when it never does.
    task automatic wait_out(input int bit_i, input logic val, input int exp_n, input string nm);
        int n;
        bit hit;
        logic [N-1:0] cur;
        n = 0;
        hit = 0;
        while (n < 40 && !hit) begin
            @(posedge clk);
            #1;
            n++;
            cur = {key, sw};
            if (cur[bit_i] == val) hit = 1;
        end
        chk(nm, hit ? 32'(n) : 32'hFFFF_FFFF, 32'(exp_n));
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : stim
        int sw_at;
        int key_at;
        int p;
        reset_n = 1'b0;
        sw_raw  = 10'h3FF;
        key_raw = 4'h0;
`ifdef GPIO_KEY_EVENT_EN
        kp_clr  = '0;
`endif
        // 1: reset, then all channels change together.
        @(posedge clk);
        tick(2);
        chk("t1_rst_sw", 32'(sw), 32'h0);
        chk("t1_rst_key", 32'(key), 32'h0);
        reset_n = 1'b1;
        wait_out(0, 1'b1, 11, "t1_latency");
        chk("t1_sw_all", 32'(sw), 32'h3FF);
        chk("t1_key_all", 32'(key), 32'hF);
        sw_raw  = '0;
        key_raw = 4'hF;
        tick(14);
`ifdef GPIO_KEY_EVENT_EN
        kp_clr = '1;
        tick(1);
        kp_clr = '0;
`endif
        tick(1);
        // 2: single switch edge.
        sw_raw[3] = 1'b1;
        wait_out(3, 1'b1, 11, "t2_sw3_latency");
        chk("t2_others", 32'(sw), 32'h008);
        // 3: short pulse filtered, then chatter restarts the count.
        key_raw[0] = 1'b0;
        tick(5);
        key_raw[0] = 1'b1;
        tick(14);
        chk("t3_short_pulse", 32'(key), 32'h0);
        key_raw[0] = 1'b0;
        tick(4);
        key_raw[0] = 1'b1;
        tick(1);
        key_raw[0] = 1'b0;
        wait_out(NSW + 0, 1'b1, 11, "t3_chatter_latency");
        key_raw[0] = 1'b1;
        tick(14);
        // 4: simultaneous change, one channel glitches on cycle 3.
        sw_at  = -1;
        key_at = -1;
        sw_raw[0]  = 1'b1;
        key_raw[2] = 1'b0;
        for (int c = 1; c <= 30; c++) begin
            @(posedge clk);
            #1;
            if (sw_at < 0 && sw[0]) sw_at = c;
            if (key_at < 0 && key[2]) key_at = c;
            if (c == 2) key_raw[2] = 1'b1;
            if (c == 3) key_raw[2] = 1'b0;
        end
        chk("t4_sw0_latency", 32'(sw_at), 32'd11);
        chk("t4_key2_latency", 32'(key_at), 32'd14);
        // 5: reset in the middle of a count.
        sw_raw[1] = 1'b1;
        tick(7);
        reset_n = 1'b0;
        #1;
        chk("t5_async_clear", 32'(sw), 32'h0);
        tick(2);
        reset_n = 1'b1;
        wait_out(1, 1'b1, 11, "t5_restart_latency");
        sw_raw  = '0;
        key_raw = 4'hF;
        tick(14);
`ifdef GPIO_KEY_EVENT_EN
        // 6: sticky press flags.
        kp_clr = '1;
        tick(1);
        kp_clr = '0;
        chk("t6_pre_clear", 32'(kp), 32'h0);
        key_raw[1] = 1'b0;
        wait_out(NSW + 1, 1'b1, 11, "t6_press_latency");
        chk("t6_not_yet", 32'(kp), 32'h0);
        tick(1);
        chk("t6_press_set", 32'(kp), 32'h2);
        key_raw[1] = 1'b1;
        wait_out(NSW + 1, 1'b0, 11, "t6_release_latency");
        tick(2);
        chk("t6_release_hold", 32'(kp), 32'h2);
        key_raw[1] = 1'b0;
        wait_out(NSW + 1, 1'b1, 11, "t6_repress_latency");
        kp_clr[1] = 1'b1;
        tick(1);
        kp_clr[1] = 1'b0;
        chk("t6_set_wins", 32'(kp), 32'h2);
        kp_clr[1] = 1'b1;
        tick(1);
        kp_clr[1] = 1'b0;
        chk("t6_clear", 32'(kp), 32'h0);
        key_raw[1] = 1'b1;
        wait_out(NSW + 1, 1'b0, 11, "t6_rerelease_latency");
        tick(3);
        chk("t6_release_noset", 32'(kp), 32'h0);
`endif
        // Random phase: alternating busy/quiet stretches, occasional reset.
        for (int c = 0; c < 1500; c++) begin
            p = ((c / 300) % 2 == 1) ? 30 : 6;
            for (int b = 0; b < NSW; b++)
                if ($urandom_range(0, p - 1) == 0) sw_raw[b] = ~sw_raw[b];
            for (int b = 0; b < NKEY; b++)
                if ($urandom_range(0, p - 1) == 0) key_raw[b] = ~key_raw[b];
`ifdef GPIO_KEY_EVENT_EN
            for (int b = 0; b < NKEY; b++) kp_clr[b] = ($urandom_range(0, 7) == 0);
`endif
            if ($urandom_range(0, 499) == 0) begin
                reset_n = 1'b0;
                tick(2);
                reset_n = 1'b1;
            end
            tick(1);
        end
        tick(2);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
